// File: rtl/hpu_pkg.sv
// rtl/hpu_pkg.sv - shared HPU register-file types and widths
package hpu_pkg;

    localparam int PHY_SR_LEN   = 64;
    localparam int PHY_SR_IDX_W = $clog2(PHY_SR_LEN);
    localparam int DATA_WTH     = 32;

    typedef logic [PHY_SR_IDX_W-1:0] phy_sr_index_t;
    typedef logic [DATA_WTH-1:0]     data_t;

endpackage

// File: rtl/hpu_prf_wb_sel.sv
// rtl/hpu_prf_wb_sel.sv - N-of-M grant selector scanning upward from a rotating pointer
module hpu_prf_wb_sel #(
    parameter int NUM_REQ = 4,
    parameter int NUM_WR  = 2,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0]            vld_i,
    input  logic [PTR_W-1:0]              ptr_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_WR-1:0]             port_vld_o,
    output logic [NUM_WR-1:0][PTR_W-1:0]  port_idx_o,
    output logic [PTR_W-1:0]              last_o,
    output logic                          any_o
);

    int   cnt;
    int   idx;
    logic hit;

    // Only loop variables index the vectors, so every select stays constant after unrolling.
    always_comb begin
        gnt_o      = '0;
        port_vld_o = '0;
        port_idx_o = '0;
        last_o     = '0;
        cnt        = 0;
        idx        = 0;
        hit        = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr_i) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            hit = 1'b0;
            for (int r = 0; r < NUM_REQ; r++) begin
                if (r == idx && vld_i[r]) begin
                    hit = 1'b1;
                end
            end
            if (hit && cnt < NUM_WR) begin
                for (int r = 0; r < NUM_REQ; r++) begin
                    if (r == idx) begin
                        gnt_o[r] = 1'b1;
                    end
                end
                for (int k = 0; k < NUM_WR; k++) begin
                    if (k == cnt) begin
                        port_vld_o[k] = 1'b1;
                        port_idx_o[k] = PTR_W'(idx);
                    end
                end
                last_o = PTR_W'(idx);
                cnt    = cnt + 1;
            end
        end
    end

    assign any_o = |gnt_o;

endmodule

// File: rtl/hpu_prf_wb_arb.sv
// rtl/hpu_prf_wb_arb.sv - PRF writeback arbiter with busy table; HPU_PRF_WB_RR_EN selects round-robin
module hpu_prf_wb_arb
    import hpu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int NUM_WR  = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_REQ-1:0]             req_vld_i,
    input  phy_sr_index_t [NUM_REQ-1:0]    req_addr_i,
    input  data_t [NUM_REQ-1:0]            req_data_i,
    output logic [NUM_REQ-1:0]             req_rdy_o,
    output phy_sr_index_t [NUM_WR-1:0]     waddr_o,
    output logic [NUM_WR-1:0]              wr_en_o,
    output data_t [NUM_WR-1:0]             wdata_o,
    input  logic [NUM_WR-1:0]              alloc_en_i,
    input  phy_sr_index_t [NUM_WR-1:0]     alloc_addr_i,
    input  logic                           flush_i,
    output logic [PHY_SR_LEN-1:0]          busy_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]             ptr;
    logic [PTR_W-1:0]             last_idx;
    logic                         any_gnt;
    logic [NUM_REQ-1:0]           sel_vld;
    logic [NUM_REQ-1:0]           gnt;
    logic [NUM_WR-1:0]            port_vld;
    logic [NUM_WR-1:0][PTR_W-1:0] port_idx;

    logic [NUM_WR-1:0]            wr_en_nxt;
    phy_sr_index_t [NUM_WR-1:0]   waddr_nxt;
    data_t [NUM_WR-1:0]           wdata_nxt;
    logic [PHY_SR_LEN-1:0]        busy_nxt;

    // Masking valids during reset and flush keeps ready low without a separate gate.
    assign sel_vld   = (rst_i && !flush_i) ? req_vld_i : '0;
    assign req_rdy_o = gnt;

    hpu_prf_wb_sel #(
        .NUM_REQ (NUM_REQ),
        .NUM_WR  (NUM_WR),
        .PTR_W   (PTR_W)
    ) u_sel (
        .vld_i      (sel_vld),
        .ptr_i      (ptr),
        .gnt_o      (gnt),
        .port_vld_o (port_vld),
        .port_idx_o (port_idx),
        .last_o     (last_idx),
        .any_o      (any_gnt)
    );

`ifdef HPU_PRF_WB_RR_EN
    logic [PTR_W-1:0] ptr_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ptr_q <= '0;
        end else if (any_gnt) begin
            ptr_q <= (last_idx == PTR_W'(NUM_REQ - 1)) ? '0 : last_idx + PTR_W'(1);
        end
    end

    assign ptr = ptr_q;
`else
    logic sel_unused;

    assign ptr        = '0;
    assign sel_unused = ^{last_idx, any_gnt};
`endif

    // Address 0 is the hardwired zero register: the grant completes but no write happens.
    always_comb begin
        wr_en_nxt = '0;
        waddr_nxt = '0;
        wdata_nxt = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            if (port_vld[k]) begin
                waddr_nxt[k] = req_addr_i[port_idx[k]];
                wdata_nxt[k] = req_data_i[port_idx[k]];
                wr_en_nxt[k] = (req_addr_i[port_idx[k]] != '0);
            end
        end
    end

    always_comb begin
        busy_nxt = busy_o;
        for (int k = 0; k < NUM_WR; k++) begin
            if (wr_en_nxt[k]) begin
                busy_nxt[waddr_nxt[k]] = 1'b0;
            end
        end
        for (int k = 0; k < NUM_WR; k++) begin
            if (alloc_en_i[k]) begin
                busy_nxt[alloc_addr_i[k]] = 1'b1;
            end
        end
        if (flush_i) begin
            busy_nxt = '0;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_en_o <= '0;
            waddr_o <= '0;
            wdata_o <= '0;
            busy_o  <= '0;
        end else begin
            wr_en_o <= wr_en_nxt;
            waddr_o <= waddr_nxt;
            wdata_o <= wdata_nxt;
            busy_o  <= busy_nxt;
        end
    end

endmodule
